uart_boot_loader: RTL and testbench

//  Boot-time writer for the instruction-memory boot port. Takes a byte stream from the

---
 rtl/uart_boot_loader.sv | 180 ++++++++++++++++++
 tb/tb_uart_boot_loader.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_boot_loader.sv
// Boot-time I-Mem writer: assembles little-endian words from a UART byte stream
// framed as LEN_LO, LEN_HI, data bytes, CHK, and drives the I-Mem boot write port.
module uart_boot_loader #(
  parameter int BITS    = 32,
  parameter int ADDRW   = 13,
  parameter int TIMEOUT = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             boot_req,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic [BITS-1:0]  wdata_data,
  output logic [ADDRW:0]   wdata_addr,
  output logic             we_boot,
  output logic             bootloading,
  output logic             boot_done,
  output logic             boot_err,
  output logic [2:0]       dbg_state_o
);

  localparam int NB  = BITS / 8;
  localparam int BW  = (NB > 1) ? $clog2(NB) : 1;
  localparam int AW1 = ADDRW + 1;
  localparam int GW  = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] LAST_B  = BW'(NB - 1);
  localparam logic [GW-1:0] TO_LAST = GW'(TIMEOUT - 1);
  localparam logic [31:0]   MAXW    = 32'(2 ** AW1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_CHK    = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      len_lo_q, len_lo_d;
  logic [15:0]     last_idx_q, last_idx_d;
  logic [BW-1:0]   byte_idx_q, byte_idx_d;
  logic [ADDRW:0]  word_idx_q, word_idx_d;
  logic [7:0]      sum_q, sum_d;
  logic [BITS-1:0] shift_q, shift_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [BITS-1:0] wdata_q, wdata_d;
  logic [ADDRW:0]  addr_q, addr_d;
  logic            we_q, we_d;
  logic            done_q, done_d;

  logic [BITS-1:0] word_cur;
  logic [15:0]     n_rx;
  logic            loading;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_lo_q   <= '0;
      last_idx_q <= '0;
      byte_idx_q <= '0;
      word_idx_q <= '0;
      sum_q      <= '0;
      shift_q    <= '0;
      gap_q      <= '0;
      wdata_q    <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_lo_q   <= len_lo_d;
      last_idx_q <= last_idx_d;
      byte_idx_q <= byte_idx_d;
      word_idx_q <= word_idx_d;
      sum_q      <= sum_d;
      shift_q    <= shift_d;
      gap_q      <= gap_d;
      wdata_q    <= wdata_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    len_lo_d   = len_lo_q;
    last_idx_d = last_idx_q;
    byte_idx_d = byte_idx_q;
    word_idx_d = word_idx_q;
    sum_d      = sum_q;
    shift_d    = shift_q;
    gap_d      = gap_q;
    wdata_d    = wdata_q;
    addr_d     = addr_q;
    we_d       = 1'b0;
    done_d     = 1'b0;

    word_cur = shift_q;
    word_cur[8*byte_idx_q +: 8] = rx_data;
    n_rx    = {rx_data, len_lo_q};
    loading = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
              (state_q == S_DATA)   || (state_q == S_CHK);

    // Inter-byte watchdog; a timeout drops any partial word without writing it.
    if (loading) begin
      if (rx_valid)                gap_d = '0;
      else if (gap_q == TO_LAST)   state_d = S_ERR;
      else                         gap_d = gap_q + GW'(1);
    end

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (boot_req) begin
          state_d    = S_LEN_LO;
          byte_idx_d = '0;
          word_idx_d = '0;
          sum_d      = '0;
          shift_d    = '0;
          gap_d      = '0;
        end
      end
      S_LEN_LO: begin
        if (rx_valid) begin
          len_lo_d = rx_data;
          state_d  = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (rx_valid) begin
          if (n_rx == 16'd0)            state_d = S_CHK;
          else if (32'(n_rx) > MAXW)    state_d = S_ERR;
          else begin
            last_idx_d = n_rx - 16'd1;
            state_d    = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          sum_d   = sum_q + rx_data;
          shift_d = word_cur;
          if (byte_idx_q == LAST_B) begin
            byte_idx_d = '0;
            we_d       = 1'b1;
            wdata_d    = word_cur;
            addr_d     = word_idx_q;
            word_idx_d = word_idx_q + AW1'(1);
            if (32'(word_idx_q) == 32'(last_idx_q)) state_d = S_CHK;
          end else begin
            byte_idx_d = byte_idx_q + BW'(1);
          end
        end
      end
      S_CHK: begin
        if (rx_valid) begin
          if (rx_data == sum_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign wdata_data  = wdata_q;
  assign wdata_addr  = addr_q;
  assign we_boot     = we_q;
  assign boot_done   = done_q;
  assign bootloading = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                       (state_q == S_DATA)   || (state_q == S_CHK);
  assign boot_err    = (state_q == S_ERR);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench for uart_boot_loader: frame-level reference model computes
// expected I-Mem writes and outcome; a negedge monitor scores every write.
module tb_uart_boot_loader;

  localparam int BITS = 32;
  localparam int AW   = 13;
  localparam int TO   = 200;
  localparam int NB   = BITS / 8;
  localparam int EW   = AW + 1 + BITS;

  logic            clk = 1'b0;
  logic            rst;
  logic            boot_req;
  logic [7:0]      rx_data;
  logic            rx_valid;
  logic [BITS-1:0] wdata_data;
  logic [AW:0]     wdata_addr;
  logic            we_boot;
  logic            bootloading;
  logic            boot_done;
  logic            boot_err;
  logic [2:0]      dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [EW-1:0]   exp_q[$];
  logic [BITS-1:0] fw_q[$];

  uart_boot_loader #(.BITS(BITS), .ADDRW(AW), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .boot_req    (boot_req),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .wdata_data  (wdata_data),
    .wdata_addr  (wdata_addr),
    .we_boot     (we_boot),
    .bootloading (bootloading),
    .boot_done   (boot_done),
    .boot_err    (boot_err),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest expected {addr,data}.
  always @(negedge clk) begin
    if (!rst && we_boot) begin
      if (exp_q.size() == 0) begin
        check("we_spurious", 64'(we_boot), 64'd0);
      end else begin
        check("wr_word", 64'({wdata_addr, wdata_data}), 64'(exp_q.pop_front()));
        check("we_while_loading", 64'(bootloading), 64'd1);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic pulse_boot();
    @(negedge clk);
    boot_req = 1'b1;
    @(negedge clk);
    boot_req = 1'b0;
  endtask

  // Drive one byte; at the following negedge the write strobe must equal exp_we.
  task automatic send_byte(input logic [7:0] b, input bit exp_we, input bit with_req, input bit gap);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    boot_req = with_req;
    @(negedge clk);
    rx_valid = 1'b0;
    boot_req = 1'b0;
    check("we_latency", 64'(we_boot), 64'(exp_we));
    if (gap) repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  // Reference model at frame level: words in fw_q are sent little-endian;
  // every word is expected written in order at addresses 0..N-1, and the
  // load ends in DONE iff CHK equals the byte sum mod 256.
  task automatic run_frame(input bit bad, input int req_at, input bit combo_start);
    int n;
    int k;
    logic [7:0] sum;
    logic [7:0] b;
    logic [7:0] chk;
    logic [AW:0] a;
    n   = fw_q.size();
    sum = 8'd0;
    k   = 0;
    if (combo_start) begin
      @(negedge clk);
      boot_req = 1'b1;
      rx_valid = 1'b1;
      rx_data  = 8'hAA;
      @(negedge clk);
      boot_req = 1'b0;
      rx_valid = 1'b0;
    end else begin
      pulse_boot();
    end
    check("start_bootloading", 64'(bootloading), 64'd1);
    check("start_err_clear", 64'(boot_err), 64'd0);
    send_byte(n[7:0], 1'b0, 1'b0, 1'b1);
    send_byte(n[15:8], 1'b0, 1'b0, 1'b1);
    for (int w = 0; w < n; w++) begin
      a = w[AW:0];
      exp_q.push_back({a, fw_q[w]});
      for (int j = 0; j < NB; j++) begin
        b   = fw_q[w][8*j +: 8];
        sum = sum + b;
        send_byte(b, j == NB - 1, k == req_at, 1'b1);
        k++;
      end
    end
    chk = bad ? sum + 8'd1 : sum;
    send_byte(chk, 1'b0, 1'b0, 1'b0);
    check("end_done", 64'(boot_done), 64'(!bad));
    check("end_err", 64'(boot_err), 64'(bad));
    check("end_bootloading", 64'(bootloading), 64'd0);
    @(negedge clk);
    check("done_one_cycle", 64'(boot_done), 64'd0);
    check("writes_drained", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst      = 1'b1;
    boot_req = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_bootloading", 64'(bootloading), 64'd0);
    check("rst_we", 64'(we_boot), 64'd0);
    check("rst_data", 64'(wdata_data), 64'd0);
    check("rst_addr", 64'(wdata_addr), 64'd0);
    check("rst_done_err", 64'({boot_done, boot_err}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Reset mid-DATA after 6 data bytes
    pulse_boot();
    send_byte(8'h02, 1'b0, 1'b0, 1'b1);
    send_byte(8'h00, 1'b0, 1'b0, 1'b1);
    exp_q.push_back({14'd0, 32'h0403_0201});
    send_byte(8'h01, 1'b0, 1'b0, 1'b1);
    send_byte(8'h02, 1'b0, 1'b0, 1'b1);
    send_byte(8'h03, 1'b0, 1'b0, 1'b1);
    send_byte(8'h04, 1'b1, 1'b0, 1'b1);
    send_byte(8'h05, 1'b0, 1'b0, 1'b1);
    send_byte(8'h06, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_bootloading", 64'(bootloading), 64'd0);
    check("midrst_outs", 64'({we_boot, boot_done, boot_err, wdata_addr}), 64'd0);
    check("midrst_data", 64'(wdata_data), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    check("midrst_drained", 64'(exp_q.size()), 64'd0);

    // Directed frame, good and bad checksum
    fw_q = '{32'h0000_0013, 32'h0010_0093};
    run_frame(1'b0, -1, 1'b0);
    run_frame(1'b1, -1, 1'b0);

    // Zero-length frame, then oversized length
    fw_q = {};
    run_frame(1'b0, -1, 1'b0);
    pulse_boot();
    send_byte(8'hFF, 1'b0, 1'b0, 1'b1);
    send_byte(8'hFF, 1'b0, 1'b0, 1'b0);
    check("oversize_err", 64'(boot_err), 64'd1);
    check("oversize_bootloading", 64'(bootloading), 64'd0);

    // Stall after 2 data bytes: error exactly TO idle cycles later, no write
    pulse_boot();
    send_byte(8'h01, 1'b0, 1'b0, 1'b1);
    send_byte(8'h00, 1'b0, 1'b0, 1'b1);
    send_byte(8'h11, 1'b0, 1'b0, 1'b1);
    send_byte(8'h22, 1'b0, 1'b0, 1'b0);
    repeat (TO - 1) @(negedge clk);
    check("timeout_not_yet", 64'({bootloading, boot_err}), 64'b10);
    @(negedge clk);
    check("timeout_err", 64'({bootloading, boot_err}), 64'b01);
    fw_q = '{32'hDEAD_BEEF};
    run_frame(1'b0, -1, 1'b0);

    // Bytes while idle are ignored; boot_req mid-DATA ignored; boot_req+byte drops the byte
    for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b1);
    check("idle_bytes_bootloading", 64'(bootloading), 64'd0);
    check("idle_bytes_flags", 64'({boot_done, boot_err}), 64'd0);
    fw_q = '{32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_F0F0};
    run_frame(1'b0, 5, 1'b1);

    // Randomized frames
    for (int t = 0; t < 10; t++) begin
      int n;
      int req_at;
      n = $urandom_range(1, 6);
      fw_q = {};
      for (int i = 0; i < n; i++) fw_q.push_back($urandom);
      req_at = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, n * NB - 1)) : -1;
      run_frame($urandom_range(0, 3) == 0, req_at, 1'($urandom_range(0, 1)));
    end

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
